// File: rtl/prog_loader_mem.sv
// 16x8 program memory for the 4-bit CPU with a valid/ready byte-stream loader.
// A load is 16 image bytes plus one checksum byte; the CPU is held in reset until a load verifies.
module prog_loader_mem #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit START_IN_LOAD  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] adr,
  output logic [7:0] dout,
  output logic       cpu_reset_n,
  input  logic       load_req,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CSUM = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;
  localparam logic [1:0] S_RST  = START_IN_LOAD ? S_LOAD : S_RUN;

  // Counter only needs to reach TIMEOUT_CYCLES-1; the idle cycle after that is the terminal one.
  localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit            TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       sum_q, sum_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [15:0][7:0] mem_q;
  logic             cpu_rst_n_q;
  logic             xfer, wr_en, tmo_hit;

  assign rx_ready    = (state_q == S_LOAD) || (state_q == S_CSUM);
  assign busy        = rx_ready;
  assign err         = (state_q == S_ERR);
  assign xfer        = rx_valid && rx_ready;
  assign dout        = mem_q[adr];
  assign cpu_reset_n = cpu_rst_n_q;
  // A transfer on the terminal cycle wins over the timeout.
  assign tmo_hit     = TMO_EN && busy && !xfer && (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    tmo_d   = '0;
    wr_en   = 1'b0;
    case (state_q)
      S_RUN, S_ERR: begin
        if (load_req) begin
          state_d = S_LOAD;
          cnt_d   = 4'd0;
          sum_d   = 8'h00;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          wr_en = 1'b1;
          sum_d = sum_q + rx_data;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = S_CSUM;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        if (xfer) begin
          state_d = (8'(sum_q + rx_data) == 8'h00) ? S_RUN : S_ERR;
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RST;
      cnt_q       <= 4'd0;
      sum_q       <= 8'h00;
      tmo_q       <= '0;
      mem_q       <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      cpu_rst_n_q <= (state_q == S_RUN);
      if (wr_en) mem_q[cnt_q] <= rx_data;
    end
  end

endmodule

// File: tb/tb_prog_loader_mem.sv
// Directed + randomized bench for prog_loader_mem; expectations come from a
// transaction-level model (image array, running byte sum, accepted-byte count).
module tb_prog_loader_mem;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] adr = 4'd0;
  logic [7:0] dout, dout1;
  logic       cpu_reset_n, cpu_reset_n1;
  logic       load_req = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready, rx_ready1, busy, busy1, err, err1;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_m [16];
  logic [7:0] prog [17];
  int         nacc;
  logic [7:0] sum_m;

  prog_loader_mem #(.TIMEOUT_CYCLES(8), .START_IN_LOAD(1'b0)) dut (
    .clk(clk), .reset(reset), .adr(adr), .dout(dout), .cpu_reset_n(cpu_reset_n),
    .load_req(load_req), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .err(err)
  );

  prog_loader_mem #(.TIMEOUT_CYCLES(0), .START_IN_LOAD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .adr(adr), .dout(dout1), .cpu_reset_n(cpu_reset_n1),
    .load_req(load_req), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready1),
    .busy(busy1), .err(err1)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      adr = 4'(a);
      #1;
      chk(tag, dout, mem_m[a]);
    end
  endtask

  task automatic start_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_err", err, 0);
    nacc  = 0;
    sum_m = 8'h00;
  endtask

  // Offer one byte after `gap` idle cycles; model updates once it is accepted.
  task automatic send(input logic [7:0] b, input int gap, input bit keep_valid);
    int w;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    w = 0;
    while (!rx_ready && w < 16) begin
      @(negedge clk);
      w++;
    end
    if (!rx_ready) begin
      chk("ready_wait", rx_ready, 1);
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (nacc < 16) mem_m[nacc] = b;
    sum_m = sum_m + b;
    nacc++;
    if (!keep_valid) rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] csum_of16();
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 16; i++) s = s + prog[i];
    return 8'(8'h00 - s);
  endfunction

  // Ends after the checksum byte: verifies outcome, CPU reset release and image.
  task automatic finish_and_check(input string tag);
    bit ok;
    ok = (sum_m == 8'h00);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, {31'd0, !ok});
    chk({tag, "_rdy"}, rx_ready, 0);
    chk({tag, "_cpu0"}, cpu_reset_n, 0);
    @(negedge clk);
    chk({tag, "_cpu1"}, cpu_reset_n, {31'd0, ok});
    check_mem({tag, "_mem"});
    @(negedge clk);
  endtask

  task automatic run_load(input string tag, input int gmin, input int gmax);
    start_load();
    for (int i = 0; i < 17; i++) begin
      send(prog[i], $urandom_range(gmax, gmin), 1'b0);
      if (i < 16) chk({tag, "_busy_mid"}, busy, 1);
    end
    finish_and_check(tag);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_cpu", cpu_reset_n, 0);
    chk("rst_rdy", rx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst1_busy", busy1, 1);
    chk("rst1_rdy", rx_ready1, 1);
    chk("rst1_cpu", cpu_reset_n1, 0);
    chk("rst1_err", err1, 0);
    chk("rst1_dout", dout1, 0);
    check_mem("rst_mem");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_cpu", cpu_reset_n, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst1_cpu", cpu_reset_n1, 0);
    chk("post_rst1_busy", busy1, 1);

    // Good load with CPU reset timing
    prog[0] = 8'hB3;
    for (int i = 1; i < 16; i++) prog[i] = 8'(i);
    prog[16] = csum_of16();
    start_load();
    chk("good_cpu_lag", cpu_reset_n, 1);
    @(negedge clk);
    chk("good_cpu_low", cpu_reset_n, 0);
    for (int i = 0; i < 17; i++) begin
      send(prog[i], 0, 1'b0);
      if (i < 16) chk("good_busy", busy, 1);
    end
    finish_and_check("good");
    adr = 4'd0; #1; chk("good_adr0", dout, 8'hB3);
    adr = 4'd15; #1; chk("good_adr15", dout, 8'h0F);
    @(negedge clk);

    // Bad checksum, then recovery
    prog[16] = 8'h00;
    run_load("bad", 0, 0);
    @(negedge clk);
    chk("bad_cpu_held", cpu_reset_n, 0);
    chk("bad_err_held", err, 1);
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
    prog[16] = csum_of16();
    run_load("recover", 0, 3);

    // Random loads, some corrupted
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      prog[16] = csum_of16() + ((n % 2 == 1) ? 8'($urandom_range(255, 1)) : 8'h00);
      run_load("rand", 0, 3);
    end

    // Backpressure: valid toggling, load_req held, valid held past CSUM->RUN
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
    prog[16] = csum_of16();
    start_load();
    load_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(prog[i], 1, 1'b0);
      chk("bp_busy", busy, 1);
    end
    load_req = 1'b0;
    send(prog[16], 1, 1'b1);
    rx_data = 8'hEE;
    chk("bp_cnt", nacc, 17);
    chk("bp_cpu0", cpu_reset_n, 0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_no18_rdy", rx_ready, 0);
      chk("bp_no18_busy", busy, 0);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("bp_cpu1", cpu_reset_n, 1);
    chk("bp_err", err, 0);
    check_mem("bp_mem");
    @(negedge clk);

    // Timeout after 5 bytes
    start_load();
    for (int i = 0; i < 5; i++) send(8'($urandom), 0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("tmo_err", err, {31'd0, k == 8});
    end
    chk("tmo_cpu", cpu_reset_n, 0);
    check_mem("tmo_mem");
    @(negedge clk);

    // Byte on the terminal cycle is accepted and the load completes
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
    prog[16] = csum_of16();
    start_load();
    for (int i = 0; i < 3; i++) send(prog[i], 0, 1'b0);
    send(prog[3], 7, 1'b0);
    chk("term_err", err, 0);
    chk("term_busy", busy, 1);
    for (int i = 4; i < 17; i++) send(prog[i], 0, 1'b0);
    finish_and_check("term");

    // Async reset mid-load
    start_load();
    for (int i = 0; i < 7; i++) send(8'($urandom), 0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    chk("arst_busy", busy, 0);
    chk("arst_cpu", cpu_reset_n, 0);
    chk("arst_rdy", rx_ready, 0);
    check_mem("arst_mem");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("arst_rel_cpu", cpu_reset_n, 1);
    chk("arst_rel_busy", busy, 0);
    chk("arst_rel_err", err, 0);
    check_mem("arst_rel_mem");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
